// File: rtl/mem_responder_if.sv
// Core-to-responder request/response bundle: a single outstanding access,
// held by the core until ready is seen.
interface mem_responder_if;
  logic        read;
  logic        write;
  logic [31:0] addr;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic        ready;
  logic        err;

  modport master (output read, write, addr, dataIn, input dataOut, ready, err);
  modport slave  (input read, write, addr, dataIn, output dataOut, ready, err);
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed number of wait states.
// One transaction at a time; bad requests complete with err at normal timing.
module mem_responder #(
  parameter int ADDR_W = 8,
  parameter int WAIT   = 2
) (
  input  logic            CLK,
  input  logic            RES,
  mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic                r_rd, r_wr, r_bad;
  logic [ADDR_W-1:0]   r_idx;
  logic [31:0]         r_data;
  logic [31:0]         r_dout;
  logic                r_ready, r_err;
  logic [31:0]         r_mem [2**ADDR_W];

  logic                w_accept, w_req_bad;
  logic                w_rd, w_wr, w_bad, w_enter, w_ok;
  logic [ADDR_W-1:0]   w_idx;
  logic [31:0]         w_data;

  assign w_accept  = (r_state == ST_IDLE) && (bus.read || bus.write);
  assign w_req_bad = (bus.read && bus.write) || (|bus.addr[1:0]) ||
                     (|bus.addr[31:ADDR_W+2]);

  // With WAIT=0 the access happens at the accepting edge, so use live inputs.
  assign w_rd   = w_accept ? bus.read                : r_rd;
  assign w_wr   = w_accept ? bus.write               : r_wr;
  assign w_bad  = w_accept ? w_req_bad               : r_bad;
  assign w_idx  = w_accept ? bus.addr[ADDR_W+1:2]    : r_idx;
  assign w_data = w_accept ? bus.dataIn              : r_data;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (WAIT == 0) begin
          w_state_nxt = ST_RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = 4'(WAIT);
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered on the edge entering RESP so they line up with it.
  assign w_enter = (w_state_nxt == ST_RESP);
  assign w_ok    = w_enter && !w_bad;

  always_ff @(posedge CLK) begin
    if (!RES) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_dout  <= 32'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_bad   <= 1'b0;
      r_idx   <= '0;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ready <= w_enter;
      r_err   <= w_enter && w_bad;
      if (w_accept) begin
        r_rd   <= bus.read;
        r_wr   <= bus.write;
        r_bad  <= w_req_bad;
        r_idx  <= bus.addr[ADDR_W+1:2];
        r_data <= bus.dataIn;
      end
      if (w_ok && w_rd) r_dout <= r_mem[w_idx];
    end
  end

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge CLK) begin
    if (RES && w_ok && w_wr) r_mem[w_idx] <= w_data;
  end

  assign bus.dataOut = r_dout;
  assign bus.ready   = r_ready;
  assign bus.err     = r_err;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model checked every cycle on the
// default instance, plus literal checks and a WAIT=0 instance.
module tb_mem_responder;
  localparam int WAIT = 2;

  logic CLK, RES;
  int   tests = 0, fails = 0;
  int   cyc = 0;

  mem_responder_if b();
  mem_responder_if b0();

  mem_responder #(.ADDR_W(8), .WAIT(WAIT)) u_dut (.CLK(CLK), .RES(RES), .bus(b));
  mem_responder #(.ADDR_W(8), .WAIT(0))    u_w0  (.CLK(CLK), .RES(RES), .bus(b0));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted request completes WAIT edges later, next accept WAIT+2 edges later.
  bit          pend = 0, p_err, p_wr;
  int          rdy_edge, next_free = 0, p_idx;
  logic [31:0] p_data;
  logic [31:0] m_mem [256];
  logic [31:0] exp_dout = 0;
  bit          exp_rdy = 0, exp_err = 0;

  always @(posedge CLK) begin
    cyc++;
    if (!RES) begin
      pend = 0; next_free = cyc + 1;
      exp_dout = 0; exp_rdy = 0; exp_err = 0;
    end else begin
      exp_rdy = 0; exp_err = 0;
      if (!pend && cyc >= next_free && (b.read || b.write)) begin
        p_err  = (b.read && b.write) || (b.addr % 4 != 0) || (b.addr >= 32'h400);
        p_wr   = b.write;
        p_idx  = int'(b.addr / 4) % 256;
        p_data = b.dataIn;
        pend = 1; rdy_edge = cyc + WAIT; next_free = cyc + WAIT + 2;
      end
      if (pend && cyc == rdy_edge) begin
        exp_rdy = 1; exp_err = p_err; pend = 0;
        if (!p_err) begin
          if (p_wr) m_mem[p_idx] = p_data;
          else      exp_dout = m_mem[p_idx];
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      check("ready", {31'd0, b.ready}, {31'd0, exp_rdy});
      check("err",   {31'd0, b.err},   {31'd0, exp_err});
      check("dataOut", b.dataOut, exp_dout);
    end
  end

  int r_acc, r_done;
  bit r_err;

  task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input bit jitter);
    @(negedge CLK);
    b.read = rd; b.write = wr; b.addr = a; b.dataIn = d;
    r_acc = cyc + 1; r_done = -1; r_err = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (b.ready) begin r_done = cyc; r_err = b.err; break; end
      if (jitter) begin
        b.read = 1'($urandom); b.write = 1'($urandom);
        b.addr = $urandom; b.dataIn = $urandom;
      end
    end
    b.read = 0; b.write = 0;
    if (r_done < 0) begin
      tests++; fails++;
      $display("FAIL timeout: no ready for addr %h", a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 0;
    b.read = 0; b.write = 0; b.addr = 0; b.dataIn = 0;
    b0.read = 0; b0.write = 0; b0.addr = 0; b0.dataIn = 0;
    repeat (3) @(negedge CLK);
    check("rst_dout", b.dataOut, 32'd0);
    check("rst_ready", {31'd0, b.ready}, 32'd0);
    check("w0_rst_dout", b0.dataOut, 32'd0);
    RES = 1;

    // Basic write then read, latency: ready seen WAIT edges after accept edge
    req(0, 1, 32'h10, 32'hDEADBEEF, 0);
    check("lat_wr", r_done - r_acc, 32'd2);
    check("wr_err", {31'd0, r_err}, 32'd0);
    req(1, 0, 32'h10, 32'h0, 0);
    check("lat_rd", r_done - r_acc, 32'd2);
    check("rd_data", b.dataOut, 32'hDEADBEEF);

    // Conflicting read+write rejected, memory intact
    req(0, 1, 32'h20, 32'h0BADF00D, 0);
    req(1, 1, 32'h20, 32'hFFFFFFFF, 0);
    check("rw_err", {31'd0, r_err}, 32'd1);
    check("lat_rw", r_done - r_acc, 32'd2);
    req(1, 0, 32'h20, 32'h0, 0);
    check("rw_keep", b.dataOut, 32'h0BADF00D);

    // Misaligned / out-of-range, plus the last legal word
    req(0, 1, 32'h3FC, 32'h600DCAFE, 0);
    req(1, 0, 32'h3FC, 32'h0, 0);
    check("top_word", b.dataOut, 32'h600DCAFE);
    req(1, 0, 32'h10, 32'h0, 0);
    req(1, 0, 32'h402, 32'h0, 0);
    check("misal_err", {31'd0, r_err}, 32'd1);
    req(1, 0, 32'h400, 32'h0, 0);
    check("oor_err", {31'd0, r_err}, 32'd1);
    check("err_keep", b.dataOut, 32'hDEADBEEF);

    // Reset at the edge that would enter RESP of a pending write
    req(0, 1, 32'h0, 32'h55AA55AA, 0);
    @(negedge CLK);
    b.write = 1; b.addr = 0; b.dataIn = 32'h12345678;
    @(negedge CLK);
    @(negedge CLK);
    b.write = 0; RES = 0;
    @(negedge CLK);
    check("rst_no_ready", {31'd0, b.ready}, 32'd0);
    check("rst_dout2", b.dataOut, 32'd0);
    @(negedge CLK);
    RES = 1;
    req(1, 0, 32'h0, 32'h0, 0);
    check("rst_mem_kept", b.dataOut, 32'h55AA55AA);

    // Inputs jittered while busy must not affect the access
    req(0, 1, 32'h30, 32'hCAFEF00D, 0);
    req(1, 0, 32'h30, 32'h0, 1);
    check("jit_rd", b.dataOut, 32'hCAFEF00D);
    req(0, 1, 32'h34, 32'h11112222, 1);
    req(1, 0, 32'h34, 32'h0, 0);
    check("jit_wr", b.dataOut, 32'h11112222);

    // WAIT=0 instance: immediate ready, held read pulses every other cycle
    @(negedge CLK);
    b0.write = 1; b0.addr = 32'h4; b0.dataIn = 32'hA5;
    @(negedge CLK);
    check("w0_wr_ready", {31'd0, b0.ready}, 32'd1);
    b0.write = 0; b0.read = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("w0_pulse", {31'd0, b0.ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check("w0_err", {31'd0, b0.err}, 32'd0);
      if (i % 2 == 1) check("w0_data", b0.dataOut, 32'hA5);
    end
    b0.read = 0;

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
